// File: rtl/scope_capture_ctrl_if.sv
// Register bus, sample stream and capture-buffer write port of the scope capture controller.
interface scope_capture_ctrl_if #(
   parameter int AW = 10,
   parameter int DW = 9
);
   logic          chipselect;
   logic          write;
   logic [2:0]    address;
   logic [15:0]   writedata;
   logic [DW-1:0] sample;
   logic          valid;
   logic          vblank;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_en;

   modport master (
      output chipselect, write, address, writedata, sample, valid, vblank,
      input  wr_addr, wr_data, wr_en
   );

   modport slave (
      input  chipselect, write, address, writedata, sample, valid, vblank,
      output wr_addr, wr_data, wr_en
   );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture controller: edge/auto trigger, double-buffered capture
// of DEPTH samples, bank swap on vertical blank.
module scope_capture_ctrl #(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int DW    = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   scope_capture_ctrl_if.slave  bus,
   output logic                 bank_sel,
   output logic                 full,
   output logic [11:0]          trig,
   output logic                 rising,
   output logic [1:0]           state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CAP = 2'd2, S_SWAP = 2'd3} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic          bank_q, bank_d;
   logic [8:0]    level_q, level_d;
   logic          rising_q, rising_d;
   logic [1:0]    mode_q, mode_d;
   logic [15:0]   timeout_q, timeout_d;
   logic [DW-1:0] prev_q, prev_d;
   logic          prev_ok_q, prev_ok_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          wr_en;

   logic          wr_fire, arm, stop, hit, edge_hit, to_hit, last;
   logic [15:0]   smp_x, prv_x, lvl_x, cnt_inc;

   always_comb begin
      wr_fire  = bus.chipselect & bus.write;
      arm      = wr_fire && (bus.address == 3'd1) && bus.writedata[3];
      stop     = wr_fire && (bus.address == 3'd3);
      smp_x    = 16'(bus.sample);
      prv_x    = 16'(prev_q);
      lvl_x    = 16'(level_q);
      cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      edge_hit = bus.valid && prev_ok_q &&
                 (rising_q ? (prv_x < lvl_x && smp_x >= lvl_x)
                           : (prv_x > lvl_x && smp_x <= lvl_x));
      // Auto mode forces a trigger once the timeout elapses; zero disables it.
      to_hit   = bus.valid && (mode_q == 2'b00) && (timeout_q != 16'd0) &&
                 ((17'(cnt_q) + 17'd1) >= 17'(timeout_q));
      hit      = edge_hit || to_hit;
      last     = (wr_addr_q == AW'(DEPTH - 1));
   end

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      bank_d    = bank_q;
      level_d   = level_q;
      rising_d  = rising_q;
      mode_d    = mode_q;
      timeout_d = timeout_q;
      prev_d    = prev_q;
      prev_ok_d = prev_ok_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;

      if (wr_fire) begin
         case (bus.address)
            3'd0: level_d = bus.writedata[8:0];
            3'd1: begin
               rising_d = bus.writedata[0];
               mode_d   = bus.writedata[2:1];
            end
            3'd2: timeout_d = bus.writedata;
            default: ;
         endcase
      end

      if (stop) begin
         state_d   = S_IDLE;
         wr_addr_d = '0;
      end else begin
         case (state_q)
            S_IDLE: if (arm) begin
               state_d   = S_WAIT;
               wr_addr_d = '0;
               prev_ok_d = 1'b0;
               cnt_d     = '0;
            end
            S_WAIT: if (bus.valid) begin
               prev_d    = bus.sample;
               prev_ok_d = 1'b1;
               cnt_d     = cnt_inc;
               if (hit) begin
                  wr_en     = 1'b1;
                  wr_addr_d = AW'(1);
                  state_d   = S_CAP;
               end
            end
            S_CAP: if (bus.valid) begin
               wr_en = 1'b1;
               if (last) begin
                  wr_addr_d = '0;
                  state_d   = S_SWAP;
               end else begin
                  wr_addr_d = wr_addr_q + AW'(1);
               end
            end
            S_SWAP: if (bus.vblank) begin
               bank_d = ~bank_q;
               if (mode_q == 2'b10) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_WAIT;
                  wr_addr_d = '0;
                  prev_ok_d = 1'b0;
                  cnt_d     = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_WAIT;
         wr_addr_q <= '0;
         bank_q    <= 1'b0;
         level_q   <= 9'd256;
         rising_q  <= 1'b1;
         mode_q    <= 2'b00;
         timeout_q <= 16'd4096;
         prev_q    <= '0;
         prev_ok_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         bank_q    <= bank_d;
         level_q   <= level_d;
         rising_q  <= rising_d;
         mode_q    <= mode_d;
         timeout_q <= timeout_d;
         prev_q    <= prev_d;
         prev_ok_q <= prev_ok_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = bus.sample;
   assign bus.wr_en   = wr_en;
   assign bank_sel    = bank_q;
   assign full        = (state_q == S_IDLE) || (state_q == S_SWAP);
   assign trig        = {3'b000, level_q};
   assign rising      = rising_q;
   assign state       = state_q;
endmodule
